spi_slave_rx: RTL



---
 rtl/spi_pkg.sv | 13 +
 rtl/spi_edge_det.sv | 43 ++++
 rtl/spi_slave_rx.sv | 124 ++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared SPI constants and receive-state encoding used by the SPI master/slave pair.
package spi_pkg;

  localparam int SPI_DATA_W = 16;
  localparam int SPI_CNT_W  = 5;

  typedef logic [1:0] rx_state_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/spi_edge_det.sv
// Single-bit edge detector with optional two-flop synchroniser (SPI_RX_SYNC_EN).
// RST_LVL is the idle level of the line; all flops reset to it.
module spi_edge_det #(
  parameter logic RST_LVL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic sig_s,
  output logic rise,
  output logic fall
);

`ifdef SPI_RX_SYNC_EN
  logic [1:0] sync_p;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p <= {2{RST_LVL}};
    end else begin
      sync_p <= {sync_p[0], din};
    end
  end

  assign sig_s = sync_p[1];
`else
  assign sig_s = din;
`endif

  logic sig_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sig_q <= RST_LVL;
    end else begin
      sig_q <= sig_s;
    end
  end

  assign rise = sig_s & ~sig_q;
  assign fall = ~sig_s & sig_q;

endmodule

// File: rtl/spi_slave_rx.sv
// SPI receive slave (CPOL=0, MSB first), oversampled in the clk domain.
// Define SPI_RX_SYNC_EN to put two-flop synchronisers on all SPI inputs.
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W,
  parameter int CNT_W  = SPI_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_cs_l,
  input  logic              spi_sclk,
  input  logic              spi_data,
  output logic [DATA_W-1:0] dataout,
  output logic              data_valid,
  output logic              frame_err,
  output logic [CNT_W-1:0]  bit_cnt
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic              cs_s, cs_rise, cs_fall;
  logic              sclk_rise, sclk_s_unused, sclk_fall_unused;
  logic              data_s;
  logic              primed;
  logic              cs_armed;
  rx_state_t         state;
  logic [DATA_W-1:0] shreg;

  spi_edge_det #(.RST_LVL(1'b1)) u_cs_det (
    .clk   (clk),
    .reset (reset),
    .din   (spi_cs_l),
    .sig_s (cs_s),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  spi_edge_det #(.RST_LVL(1'b0)) u_sclk_det (
    .clk   (clk),
    .reset (reset),
    .din   (spi_sclk),
    .sig_s (sclk_s_unused),
    .rise  (sclk_rise),
    .fall  (sclk_fall_unused)
  );

`ifdef SPI_RX_SYNC_EN
  logic [1:0] data_sync;
  logic [1:0] prime_sync;

  // prime_sync marks when the synchronisers hold real samples rather than reset fill
  always_ff @(posedge clk) begin
    if (reset) begin
      data_sync  <= '0;
      prime_sync <= '0;
    end else begin
      data_sync  <= {data_sync[0], spi_data};
      prime_sync <= {prime_sync[0], 1'b1};
    end
  end

  assign data_s = data_sync[1];
  assign primed = prime_sync[1];
`else
  assign data_s = spi_data;
  assign primed = 1'b1;
`endif

  // The cs history resets high, so a cs still low after reset would look like a
  // fall; only accept a fall once cs has genuinely been seen high.
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_armed <= 1'b0;
    end else begin
      cs_armed <= cs_armed | (cs_s & primed);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      dataout    <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cs_fall && cs_armed) begin
            shreg   <= '0;
            bit_cnt <= '0;
            state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // cs_rise wins over a coincident sclk_rise: the bit is dropped
          if (cs_rise) begin
            frame_err <= 1'b1;
            state     <= ST_IDLE;
          end else if (sclk_rise && !cs_s) begin
            shreg   <= {shreg[DATA_W-2:0], data_s};
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (bit_cnt == LAST_BIT) begin
              dataout    <= {shreg[DATA_W-2:0], data_s};
              data_valid <= 1'b1;
              state      <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (cs_rise) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
